reg4_share_arbiter: RTL and testbench

//   Shares one WIDTH-bit synchronous-reset storage register between NREQ requesters.

---
 rtl/reg4_share_pkg.sv | 9 +
 rtl/reg4_share_arbiter_reg_nbit_sync.sv | 19 +
 rtl/reg4_share_arbiter.sv | 131 +++++++++++++
 tb/tb_reg4_share_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/reg4_share_pkg.sv
// Shared types and sizing constants for the reg4 share arbiter slice.
package reg4_share_pkg;

  typedef enum logic {IDLE, OWN} arb_state_t;

  // Hold counter width; supports HOLD_MAX up to 2**HOLD_CNT_W.
  localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/reg4_share_arbiter_reg_nbit_sync.sv
// WIDTH-bit storage register with synchronous active-high reset and load enable.
module reg_nbit_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/reg4_share_arbiter.sv
// Round-robin req/gnt arbiter sharing one register among NREQ requesters,
// with lock-based multi-cycle ownership, hold timeout and illegal-write flag.
module reg4_share_arbiter
  import reg4_share_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ-1:0]       wr_en,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  illegal_wr
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NREQ - 1);
  localparam logic [HOLD_CNT_W-1:0] CNT_LAST = HOLD_CNT_W'(HOLD_MAX - 1);

  arb_state_t            state, state_n;
  logic [NREQ-1:0]       gnt_n;
  logic [PTR_W-1:0]      ptr, ptr_n;
  logic [PTR_W-1:0]      win;
  logic [HOLD_CNT_W-1:0] cnt, cnt_n;
  logic                  timeout_n, illegal_n;
  logic                  owner_req, owner_lock, owner_wr;
  logic [WIDTH-1:0]      owner_data;

  // First set request at or after p, wrapping NREQ-1 -> 0.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] pick;
    logic             found;
    idx   = p;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == PTR_LAST) ? '0 : idx + PTR_W'(1);
    end
    return pick;
  endfunction

  // gnt is one-hot, so masking with it selects the owner's bits directly.
  always_comb begin
    owner_req  = |(req & gnt);
    owner_lock = |(lock & gnt);
    owner_wr   = |(wr_en & gnt);
    owner_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt[k])
        owner_data = wr_data[k*WIDTH +: WIDTH];
    end
  end

  reg_nbit_sync #(.WIDTH(WIDTH)) u_store (
    .clk   (clk),
    .reset (reset),
    .load  (owner_wr),
    .d     (owner_data),
    .q     (q)
  );

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    ptr_n     = ptr;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    illegal_n = |(wr_en & ~gnt);
    win       = rr_pick(req, ptr);
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n   = NREQ'(1) << win;
          state_n = OWN;
          ptr_n   = (win == PTR_LAST) ? '0 : win + PTR_W'(1);
          cnt_n   = '0;
        end
      end
      OWN: begin
        if (!owner_req || !owner_lock) begin
          gnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          gnt_n     = '0;
          state_n   = IDLE;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + HOLD_CNT_W'(1);
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      illegal_wr  <= 1'b0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      timeout_err <= timeout_n;
      illegal_wr  <= illegal_n;
    end
  end

  assign busy = (state == OWN);

endmodule

// File: tb/tb_reg4_share_arbiter.sv
// Directed, table-driven bench for reg4_share_arbiter plus multi-cycle sequences.
module tb_reg4_share_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req, lock, wr_en;
  logic [15:0] wr_data;
  logic [3:0]  gnt;
  logic [3:0]  q;
  logic        busy, timeout_err, illegal_wr;

  int tests = 0;
  int fails = 0;

  reg4_share_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .gnt         (gnt),
    .q           (q),
    .busy        (busy),
    .timeout_err (timeout_err),
    .illegal_wr  (illegal_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  wr_en;
    logic [15:0] wr_data;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        busy;
    logic        to;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [3:0] we, input logic [15:0] wd);
    reset   = r;
    req     = rq;
    lock    = lk;
    wr_en   = we;
    wr_data = wd;
  endtask

  initial begin
    drive(1'b1, 4'h0, 4'h0, 4'h0, 16'h0000);

    //            rst  req   lock  wr_en wr_data    gnt   q     busy to   ill
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'h6, 4'h0, 4'h0, 16'h0000, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'h6, 4'h0, 4'h2, 16'h00A0, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'h6, 4'h0, 4'h0, 16'h0000, 4'h4, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'h1, 4'h1, 4'h0, 16'h0000, 4'h1, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h1, 4'h1, 4'h9, 16'hF003, 4'h1, 4'h3, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'h1, 4'h1, 4'h0, 16'h0000, 4'h1, 4'h3, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 4'h0, 4'h4, 16'h0700, 4'h0, 4'h3, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].wr_en, vecs[i].wr_data);
      tick();
      chk($sformatf("v%0d gnt", i),         32'(gnt),         32'(vecs[i].gnt));
      chk($sformatf("v%0d q", i),           32'(q),           32'(vecs[i].q));
      chk($sformatf("v%0d busy", i),        32'(busy),        32'(vecs[i].busy));
      chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].to));
      chk($sformatf("v%0d illegal_wr", i),  32'(illegal_wr),  32'(vecs[i].ill));
    end

    // All requesting, no lock: 0,1,2,3,0 with an idle cycle between owners.
    drive(1'b1, 4'h0, 4'h0, 4'h0, 16'h0000);
    tick();
    drive(1'b0, 4'hF, 4'h0, 4'h0, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'h1 << (k % 4);
      tick();
      chk($sformatf("rr grant %0d", k), 32'(gnt), 32'(exp_g));
      tick();
      chk($sformatf("rr gap %0d", k), 32'(gnt), 32'h0);
    end

    // Locked owner 2 hits the hold limit after 8 grant cycles.
    drive(1'b0, 4'h0, 4'h0, 4'h0, 16'h0000);
    tick();
    drive(1'b0, 4'h4, 4'h4, 4'h0, 16'h0000);
    tick();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("hold gnt c%0d", c), 32'(gnt), 32'h4);
      chk($sformatf("hold to c%0d", c), 32'(timeout_err), 32'h0);
      if (c < 7) tick();
    end
    tick();
    chk("timeout gnt", 32'(gnt), 32'h0);
    chk("timeout pulse", 32'(timeout_err), 32'h1);
    chk("timeout busy", 32'(busy), 32'h0);
    tick();
    chk("regrant gnt", 32'(gnt), 32'h4);
    chk("regrant pulse end", 32'(timeout_err), 32'h0);

    // Reset mid-grant with a pending owner write.
    drive(1'b1, 4'h0, 4'h0, 4'h0, 16'h0000);
    tick();
    drive(1'b0, 4'h1, 4'h1, 4'h0, 16'h0000);
    tick();
    chk("pre-reset gnt", 32'(gnt), 32'h1);
    drive(1'b0, 4'h1, 4'h1, 4'h1, 16'h0009);
    tick();
    chk("pre-reset q", 32'(q), 32'h9);
    drive(1'b1, 4'h1, 4'h1, 4'h1, 16'h0005);
    tick();
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset q", 32'(q), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    drive(1'b0, 4'h3, 4'h0, 4'h0, 16'h0000);
    tick();
    chk("reset ptr", 32'(gnt), 32'h1);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 16'h0000);
    tick();
    drive(1'b0, 4'h8, 4'h0, 4'h0, 16'h0000);
    tick();
    chk("post-reset gnt3", 32'(gnt), 32'h8);
    chk("post-reset q", 32'(q), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
